// File: rtl/key_sched_ctrl_pkg.sv
// Shared AES helpers: round-count derivation, rcon sequence constants,
// GF(2^8) arithmetic and the S-box used by the key expansion.
package key_sched_ctrl_pkg;

    localparam logic [7:0] RC_INIT   = 8'h01;
    localparam logic [7:0] RC_REDUCE = 8'h1B;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int total_words_of(input int nk);
        return 4 * (nk + 7);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RC_REDUCE : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = gf_mul(x, x);
        inv = pw;
        for (int i = 0; i < 6; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/generalExpandKey.sv
// One combinational AES key-expansion step: produces the next Nk schedule
// words from the previous Nk words and the current round constant.
module generalExpandKey
    import key_sched_ctrl_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic [32*Nk-1:0] w_in,
    input  logic [31:0]      rcon,
    output logic [32*Nk-1:0] w_out
);

    logic [31:0] temp;

    // Word j of the new block depends on word j-1 of the same block.
    always_comb begin
        w_out = '0;
        temp  = w_in[32*(Nk-1) +: 32];
        for (int j = 0; j < Nk; j++) begin
            if (j == 0)
                temp = sub_word(rot_word(temp)) ^ rcon;
            else if (Nk > 6 && j == 4)
                temp = sub_word(temp);
            temp = w_in[32*j +: 32] ^ temp;
            w_out[32*j +: 32] = temp;
        end
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES key schedule controller: expands key_in one step at a time into a
// small word buffer and streams 128-bit round keys over a valid/ready port.
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [32*NK-1:0] key_in,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [127:0]    rk_data,
    output logic [3:0]      rk_index,
    output logic            busy,
    output logic            done
);

    localparam int NR          = nr_of(NK);
    localparam int TOTAL_WORDS = total_words_of(NK);
    localparam int BUF_WORDS   = NK + 3;
    localparam int CW          = $clog2(BUF_WORDS + 1);
    localparam int GW          = $clog2(TOTAL_WORDS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [32*NK-1:0]        w_curr, step_words;
    logic [32*BUF_WORDS-1:0] wbuf_q, wbuf_d;
    logic [CW-1:0]           count_q, count_d;
    logic [GW-1:0]           gen_q, gen_d;
    logic [7:0]              rc;
    logic                    accept, pop, step, last_key;
    int                      base, keep;

    generalExpandKey #(.Nk(NK)) u_expand (
        .w_in  (w_curr),
        .rcon  ({rc, 24'h0}),
        .w_out (step_words)
    );

    assign busy     = (state_q == RUN);
    assign rk_valid = busy && (count_q >= CW'(4));
    assign rk_data  = wbuf_q[127:0];
    assign accept   = start && !busy;
    assign pop      = rk_valid && rk_ready;
    assign step     = busy && (count_q < CW'(4)) && (gen_q < GW'(TOTAL_WORDS));
    assign last_key = (rk_index == 4'(NR));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pop && last_key) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Oldest word sits at the bottom; a pop shifts out four words before the
    // new step words are appended above whatever remains.
    always_comb begin
        wbuf_d  = wbuf_q;
        count_d = count_q;
        gen_d   = gen_q;
        base    = 0;
        keep    = 0;
        if (accept) begin
            wbuf_d             = '0;
            wbuf_d[32*NK-1:0]  = key_in;
            count_d            = CW'(NK);
            gen_d              = GW'(NK);
        end else if (busy) begin
            base = int'(count_q);
            if (pop) begin
                wbuf_d = wbuf_q >> 128;
                base   = base - 4;
            end
            if (step) begin
                keep = (TOTAL_WORDS - int'(gen_q) < NK) ? TOTAL_WORDS - int'(gen_q) : NK;
                for (int k = 0; k < NK; k++)
                    if (k < keep) wbuf_d[32*(base+k) +: 32] = step_words[32*k +: 32];
                gen_d = gen_q + GW'(keep);
            end
            count_d = CW'(base + keep);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            w_curr   <= '0;
            wbuf_q   <= '0;
            count_q  <= '0;
            gen_q    <= '0;
            rc       <= RC_INIT;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
            count_q <= count_d;
            gen_q   <= gen_d;
            done    <= pop && last_key;
            if (accept) begin
                w_curr   <= key_in;
                rc       <= RC_INIT;
                rk_index <= '0;
            end else begin
                if (step) begin
                    w_curr <= step_words;
                    rc     <= xtime(rc);
                end
                if (pop) rk_index <= rk_index + 4'd1;
            end
        end
    end

endmodule
